key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/keycond_pkg.sv | 24 ++
 rtl/key_channel.sv | 169 ++++++++++++++++
 rtl/key_conditioner.sv | 46 ++++
 3 files changed

// File: rtl/keycond_pkg.sv
// keycond_pkg: shared types and default constants for the key conditioner.
//   rpt_state_e : per-channel auto-repeat state (IDLE, DELAY, REPEAT)
//   rpt_t       : auto-repeat state plus its 8-bit tick counter, kept together
//                 so the whole repeat context is one inspectable struct
//   DEF_*       : default parameter values used by key_conditioner/key_channel
package keycond_pkg;

  localparam int DEF_NCH                = 3;
  localparam int DEF_DEBOUNCE_CYCLES    = 250000;  // 5 ms at 50 MHz
  localparam int DEF_REPEAT_DELAY_TICKS = 20;
  localparam int DEF_REPEAT_RATE_TICKS  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  typedef struct packed {
    rpt_state_e state;
    logic [7:0] cnt;
  } rpt_t;

endpackage

// File: rtl/key_channel.sv
// key_channel: one pushbutton channel.
//   Inverts the active-low key, runs it through a 2-flop synchronizer, debounces
//   it into `level`, and turns accepted presses into one-clock `evt` pulses that
//   are released only on frame ticks. With KEYCOND_AUTOREPEAT_EN defined a small
//   IDLE/DELAY/REPEAT machine adds auto-repeat events while the key is held.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_n       : raw asynchronous key, active low
//   tick        : one-clock frame strobe
//   repeat_en   : auto-repeat enable, sampled on ticks (ignored without the macro)
//   level       : debounced key state, active high
//   evt         : one-clock action pulse, the clock after a tick
module key_channel
  import keycond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  input  logic tick,
  input  logic repeat_en,
  output logic level,
  output logic evt
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           level_q, level_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           pending_q, pending_d;
  logic           evt_q, evt_d;

  logic rise;
  logic tick_ok;
  logic press_fire;
  logic repeat_fire;

  // Synchronizer and debounce: the counter only runs while the synchronized
  // key disagrees with the accepted level, and any agreement restarts it.
  always_comb begin
    sync1_d  = ~key_n;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign rise = level_d & ~level_q;

  // A tick that lands right after an event is ignored so evt can never be
  // high on two consecutive clocks, even with a malformed tick stream.
  assign tick_ok    = tick & ~evt_q;
  assign press_fire = tick_ok & (pending_q | rise);

  always_comb begin
    pending_d = pending_q;
    if (press_fire) begin
      pending_d = 1'b0;
    end else if (rise) begin
      pending_d = 1'b1;
    end
    // Press and repeat on the same tick merge into one pulse.
    evt_d = press_fire | repeat_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      pending_q <= 1'b0;
      evt_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      pending_q <= pending_d;
      evt_q     <= evt_d;
    end
  end

`ifdef KEYCOND_AUTOREPEAT_EN
  rpt_t       rpt_q, rpt_d;
  logic       fall;
  logic       abort;
  logic [7:0] cnt_inc;

  assign fall    = level_q & ~level_d;
  assign abort   = fall | (tick & ~repeat_en);
  assign cnt_inc = rpt_q.cnt + 8'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= '{state: IDLE, cnt: 8'd0};
    end else begin
      rpt_q <= rpt_d;
    end
  end

  // Next state. Entering DELAY also needs the key still down, otherwise a
  // press that was released before its tick would repeat forever.
  always_comb begin
    rpt_d = rpt_q;
    if (abort) begin
      rpt_d = '{state: IDLE, cnt: 8'd0};
    end else begin
      case (rpt_q.state)
        IDLE: begin
          if (press_fire && repeat_en && level_d) begin
            rpt_d = '{state: DELAY, cnt: 8'd0};
          end
        end
        DELAY: begin
          if (tick_ok) begin
            if (cnt_inc == 8'(REPEAT_DELAY_TICKS)) begin
              rpt_d = '{state: REPEAT, cnt: 8'd0};
            end else begin
              rpt_d.cnt = cnt_inc;
            end
          end
        end
        REPEAT: begin
          if (tick_ok) begin
            if (cnt_inc == 8'(REPEAT_RATE_TICKS)) begin
              rpt_d.cnt = 8'd0;
            end else begin
              rpt_d.cnt = cnt_inc;
            end
          end
        end
        default: rpt_d = '{state: IDLE, cnt: 8'd0};
      endcase
    end
  end

  // Output: a repeat event on the tick where the counter reaches its target.
  always_comb begin
    repeat_fire = 1'b0;
    if (!abort && tick_ok) begin
      case (rpt_q.state)
        DELAY:   repeat_fire = (cnt_inc == 8'(REPEAT_DELAY_TICKS));
        REPEAT:  repeat_fire = (cnt_inc == 8'(REPEAT_RATE_TICKS));
        default: repeat_fire = 1'b0;
      endcase
    end
  end
`else
  assign repeat_fire = 1'b0;
  wire unused_cfg = ^{repeat_en, 8'(REPEAT_DELAY_TICKS), 8'(REPEAT_RATE_TICKS)};
`endif

  assign level = level_q;
  assign evt   = evt_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NCH independent debounced pushbutton channels with
// frame-aligned action events and optional auto-repeat.
// Optional feature macro: KEYCOND_AUTOREPEAT_EN (auto-repeat FSM per channel).
// Ports:
//   CLOCK_50   : sole clock
//   resetn     : asynchronous active-low reset
//   key_n      : raw pushbuttons, active low, asynchronous
//   tick_input : one-clock frame strobe in the CLOCK_50 domain
//   repeat_en  : per-channel auto-repeat enable, sampled on tick_input
//   level      : debounced key state, active high
//   evt        : per-channel one-clock action pulse, issued the clock after a
//                tick; there is no backpressure, a consumer must take it then
module key_conditioner
  import keycond_pkg::*;
#(
  parameter int NCH                = DEF_NCH,
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic [NCH-1:0] key_n,
  input  logic           tick_input,
  input  logic [NCH-1:0] repeat_en,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] evt
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS)
    ) u_ch (
      .clk      (CLOCK_50),
      .rst_n    (resetn),
      .key_n    (key_n[i]),
      .tick     (tick_input),
      .repeat_en(repeat_en[i]),
      .level    (level[i]),
      .evt      (evt[i])
    );
  end

endmodule
